// File: rtl/call_stack.sv
// call_stack: hardware return stack for the DRFA processor.
// Each entry holds a return address and an ALU-flag snapshot. Supports push,
// pop, simultaneous push+pop (replace top), synchronous clear and sticky
// overflow/underflow reporting. Storage is a register array that is not reset;
// only the occupancy count and the error flags are reset.
module call_stack #(
    parameter int ADDR_WIDTH  = 9,
    parameter int FLAGS_WIDTH = 4,
    parameter int DEPTH       = 16,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_push_en,
    input  logic                   in_pop_en,
    input  logic                   in_clear,
    input  logic [ADDR_WIDTH-1:0]  in_pc,
    input  logic [FLAGS_WIDTH-1:0] in_flags,
    output logic [ADDR_WIDTH-1:0]  out_top_pc,
    output logic [FLAGS_WIDTH-1:0] out_top_flags,
    output logic [CW-1:0]          out_count,
    output logic                   out_empty,
    output logic                   out_full,
    output logic                   out_overflow,
    output logic                   out_underflow
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = ADDR_WIDTH + FLAGS_WIDTH;

    logic [EW-1:0] mem_q [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [EW-1:0] wr_data;
    logic          empty, full;
    logic [IW-1:0] top_idx;
    logic [EW-1:0] top_entry;

    // Occupancy decodes and top-of-stack selection.
    // DEPTH is a power of two, so count-1 in IW bits lands on DEPTH-1 when full.
    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == CW'(DEPTH));
        top_idx   = count_q[IW-1:0] - IW'(1);
        top_entry = mem_q[top_idx];
    end

    // Next-state decode: clear first, then push+pop, push, pop.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        wr_en       = 1'b0;
        wr_idx      = count_q[IW-1:0];
        wr_data     = {in_pc, in_flags};

        if (in_clear) begin
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else if (in_push_en && in_pop_en) begin
            if (empty) begin
                // Nothing to pop: behave as a push, but flag the bad pop.
                wr_en       = 1'b1;
                wr_idx      = '0;
                count_d     = CW'(1);
                underflow_d = 1'b1;
            end else begin
                // Replace top in place; count unchanged.
                wr_en  = 1'b1;
                wr_idx = top_idx;
            end
        end else if (in_push_en) begin
            if (full) begin
                overflow_d = 1'b1;
            end else begin
                wr_en   = 1'b1;
                count_d = count_q + CW'(1);
            end
        end else if (in_pop_en) begin
            if (empty) begin
                underflow_d = 1'b1;
            end else begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Control state: count and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Entry storage write port.
    // NOTE: the array has no reset; entries at or above count are never observed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    // Outputs: top fields forced to zero when the stack is empty.
    always_comb begin
        out_top_pc    = empty ? '0 : top_entry[EW-1:FLAGS_WIDTH];
        out_top_flags = empty ? '0 : top_entry[FLAGS_WIDTH-1:0];
        out_count     = count_q;
        out_empty     = empty;
        out_full      = full;
        out_overflow  = overflow_q;
        out_underflow = underflow_q;
    end

endmodule

// File: tb/tb_call_stack.sv
// Self-checking bench for call_stack (DEPTH=4, ADDR_WIDTH=9, FLAGS_WIDTH=4).
// A LIFO scoreboard holds expected entries as pushes are driven; pops take the
// expected entry off it and compare it with the DUT's combinational top.
module tb_call_stack;

    localparam int AW = 9;
    localparam int FW = 4;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_push_en = 1'b0;
    logic          in_pop_en = 1'b0;
    logic          in_clear = 1'b0;
    logic [AW-1:0] in_pc = '0;
    logic [FW-1:0] in_flags = '0;
    logic [AW-1:0] out_top_pc;
    logic [FW-1:0] out_top_flags;
    logic [CW-1:0] out_count;
    logic          out_empty, out_full, out_overflow, out_underflow;

    logic [AW+FW-1:0] sb [$];
    logic             m_ovf = 1'b0;
    logic             m_unf = 1'b0;
    int               n_vec = 0;
    int               n_err = 0;

    call_stack #(.ADDR_WIDTH(AW), .FLAGS_WIDTH(FW), .DEPTH(D)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_push_en   (in_push_en),
        .in_pop_en    (in_pop_en),
        .in_clear     (in_clear),
        .in_pc        (in_pc),
        .in_flags     (in_flags),
        .out_top_pc   (out_top_pc),
        .out_top_flags(out_top_flags),
        .out_count    (out_count),
        .out_empty    (out_empty),
        .out_full     (out_full),
        .out_overflow (out_overflow),
        .out_underflow(out_underflow)
    );

    always #5 clk = ~clk;

    // Compare the full visible state against the scoreboard.
    task automatic check_state(input string tag);
        logic [AW+FW-1:0] exp_top;
        exp_top = (sb.size() == 0) ? '0 : sb[sb.size()-1];
        n_vec++;
        if (out_count !== CW'(sb.size())) begin
            n_err++;
            $display("FAIL %s count: got %0d expected %0d", tag, out_count, sb.size());
        end
        n_vec++;
        if ({out_top_pc, out_top_flags} !== exp_top) begin
            n_err++;
            $display("FAIL %s top: got %h/%h expected %h/%h", tag, out_top_pc, out_top_flags,
                     exp_top[AW+FW-1:FW], exp_top[FW-1:0]);
        end
        n_vec++;
        if ({out_empty, out_full} !== {sb.size() == 0, sb.size() == D}) begin
            n_err++;
            $display("FAIL %s empty/full: got %b%b expected %b%b", tag, out_empty, out_full,
                     sb.size() == 0, sb.size() == D);
        end
        n_vec++;
        if ({out_overflow, out_underflow} !== {m_ovf, m_unf}) begin
            n_err++;
            $display("FAIL %s ovf/unf: got %b%b expected %b%b", tag, out_overflow, out_underflow,
                     m_ovf, m_unf);
        end
    endtask

    // One clock of stimulus. Popped data is checked in the same cycle, then the
    // scoreboard is updated and the post-edge state checked.
    task automatic step(input string tag, input logic push, input logic pop, input logic clr,
                        input logic [AW-1:0] pc, input logic [FW-1:0] fl);
        logic [AW+FW-1:0] exp_pop;
        in_push_en = push;
        in_pop_en  = pop;
        in_clear   = clr;
        in_pc      = pc;
        in_flags   = fl;
        #2;
        if (pop && !clr) begin
            exp_pop = (sb.size() == 0) ? '0 : sb[sb.size()-1];
            n_vec++;
            if ({out_top_pc, out_top_flags} !== exp_pop) begin
                n_err++;
                $display("FAIL %s popdata: got %h/%h expected %h/%h", tag, out_top_pc,
                         out_top_flags, exp_pop[AW+FW-1:FW], exp_pop[FW-1:0]);
            end
        end
        if (clr) begin
            sb.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (push && pop) begin
            if (sb.size() == 0) begin
                sb.push_back({pc, fl});
                m_unf = 1'b1;
            end else begin
                void'(sb.pop_back());
                sb.push_back({pc, fl});
            end
        end else if (push) begin
            if (sb.size() == D) m_ovf = 1'b1;
            else sb.push_back({pc, fl});
        end else if (pop) begin
            if (sb.size() == 0) m_unf = 1'b1;
            else void'(sb.pop_back());
        end
        @(posedge clk);
        #1;
        in_push_en = 1'b0;
        in_pop_en  = 1'b0;
        in_clear   = 1'b0;
        check_state(tag);
    endtask

    task automatic test_reset();
        #3;
        check_state("reset_no_clock");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_state("reset_idle");
    endtask

    task automatic test_fill_drain();
        step("push1", 1, 0, 0, 9'h1E1, 4'h9);
        step("push2", 1, 0, 0, 9'h0F0, 4'h1);
        step("push3", 1, 0, 0, 9'h100, 4'h5);
        step("push4", 1, 0, 0, 9'h003, 4'hF);
        n_vec++;
        if (out_full !== 1'b1) begin
            n_err++;
            $display("FAIL fill_full: got %b expected 1", out_full);
        end
        n_vec++;
        if ({out_top_pc, out_top_flags} !== {9'h003, 4'hF}) begin
            n_err++;
            $display("FAIL fill_top: got %h/%h expected 003/f", out_top_pc, out_top_flags);
        end
        for (int i = 0; i < 4; i++) step("drain", 0, 1, 0, '0, '0);
        n_vec++;
        if ({out_empty, out_overflow, out_underflow} !== 3'b100) begin
            n_err++;
            $display("FAIL drain_end: got %b expected 100",
                     {out_empty, out_overflow, out_underflow});
        end
    endtask

    task automatic test_overflow();
        step("ovf_fill1", 1, 0, 0, 9'h1E1, 4'h9);
        step("ovf_fill2", 1, 0, 0, 9'h0F0, 4'h1);
        step("ovf_fill3", 1, 0, 0, 9'h100, 4'h5);
        step("ovf_fill4", 1, 0, 0, 9'h003, 4'hF);
        step("ovf_push", 1, 0, 0, 9'h055, 4'h2);
        n_vec++;
        if ({out_overflow, out_count, out_top_pc, out_top_flags} !== {1'b1, 3'd4, 9'h003, 4'hF}) begin
            n_err++;
            $display("FAIL ovf_state: got %b/%0d/%h/%h expected 1/4/003/f",
                     out_overflow, out_count, out_top_pc, out_top_flags);
        end
        step("ovf_pop1", 0, 1, 0, '0, '0);
        step("ovf_pop2", 0, 1, 0, '0, '0);
        step("ovf_pop3", 0, 1, 0, '0, '0);
        n_vec++;
        if ({out_top_pc, out_top_flags} !== {9'h1E1, 4'h9}) begin
            n_err++;
            $display("FAIL ovf_last: got %h/%h expected 1e1/9", out_top_pc, out_top_flags);
        end
        step("ovf_pop4", 0, 1, 0, '0, '0);
        step("ovf_clear", 0, 0, 1, '0, '0);
    endtask

    task automatic test_underflow();
        step("unf_pop", 0, 1, 0, '0, '0);
        n_vec++;
        if ({out_underflow, out_count} !== {1'b1, 3'd0}) begin
            n_err++;
            $display("FAIL unf_a: got %b/%0d expected 1/0", out_underflow, out_count);
        end
        step("unf_clear", 0, 0, 1, '0, '0);
        step("unf_pushpop", 1, 1, 0, 9'h0AA, 4'h3);
        n_vec++;
        if ({out_count, out_top_pc, out_top_flags, out_underflow} !== {3'd1, 9'h0AA, 4'h3, 1'b1}) begin
            n_err++;
            $display("FAIL unf_b: got %0d/%h/%h/%b expected 1/0aa/3/1",
                     out_count, out_top_pc, out_top_flags, out_underflow);
        end
        step("unf_clear2", 0, 0, 1, '0, '0);
    endtask

    task automatic test_replace();
        step("rep_push1", 1, 0, 0, 9'h010, 4'h1);
        step("rep_push2", 1, 0, 0, 9'h020, 4'h2);
        step("rep_pushpop", 1, 1, 0, 9'h030, 4'h4);
        n_vec++;
        if ({out_count, out_top_pc, out_top_flags} !== {3'd2, 9'h030, 4'h4}) begin
            n_err++;
            $display("FAIL rep_top: got %0d/%h/%h expected 2/030/4",
                     out_count, out_top_pc, out_top_flags);
        end
        step("rep_pop", 0, 1, 0, '0, '0);
        n_vec++;
        if ({out_top_pc, out_top_flags} !== {9'h010, 4'h1}) begin
            n_err++;
            $display("FAIL rep_expose: got %h/%h expected 010/1", out_top_pc, out_top_flags);
        end
        step("rep_clear", 0, 0, 1, '0, '0);
    endtask

    task automatic test_clear_and_reset();
        for (int i = 0; i < 5; i++) step("clr_fill", 1, 0, 0, AW'(9'h040 + i), FW'(i));
        step("clr_push", 1, 0, 1, 9'h077, 4'h7);
        n_vec++;
        if ({out_count, out_overflow, out_underflow} !== {3'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL clr_prio: got %0d/%b/%b expected 0/0/0",
                     out_count, out_overflow, out_underflow);
        end
        step("rst_push1", 1, 0, 0, 9'h111, 4'hA);
        step("rst_push2", 1, 0, 0, 9'h122, 4'hB);
        step("rst_push3", 1, 0, 0, 9'h133, 4'hC);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        n_vec++;
        if ({out_count, out_top_pc, out_empty} !== {3'd0, 9'h000, 1'b1}) begin
            n_err++;
            $display("FAIL async_rst: got %0d/%h/%b expected 0/000/1",
                     out_count, out_top_pc, out_empty);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_state("after_rst");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            step("b2b_rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
                 AW'($urandom), FW'($urandom));
        end
        step("b2b_clear", 0, 0, 1, '0, '0);
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_replace();
        test_clear_and_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/call_stack.md
# call_stack

Parametrised hardware return stack for the DRFA processor. It holds return address and ALU-flag snapshots for call-subroutine and return-subroutine. It sits beside the control unit, which drives push and pop. The return address comes from the PC; the restored flags go back through the control unit's flags output. It replaces the fixed-size stack with three additions: configurable depth and widths, simultaneous push+pop (replace top), and sticky overflow/underflow error reporting.

## Interface
- ADDR_WIDTH, 9, width of stored return address (PC width)
- FLAGS_WIDTH, 4, width of stored flag snapshot
- DEPTH, 16, number of entries; power of two, ≥ 2
- CW = $clog2(DEPTH+1), derived, width of occupancy count

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_push_en  input  1  push {in_pc, in_flags} this cycle
- in_pop_en  input  1  pop top entry this cycle
- in_clear  input  1  synchronous flush; also clears error flags
- in_pc  input  ADDR_WIDTH  return address to store
- in_flags  input  FLAGS_WIDTH  flag snapshot to store
- out_top_pc  output  ADDR_WIDTH  address field of top entry; 0 when empty
- out_top_flags  output  FLAGS_WIDTH  flags field of top entry; 0 when empty
- out_count  output  CW  entries held, 0..DEPTH
- out_empty  output  1  out_count == 0
- out_full  output  1  out_count == DEPTH
- out_overflow  output  1  sticky: push attempted while full
- out_underflow  output  1  sticky: pop attempted while empty

## Operation
- Storage: DEPTH × (ADDR_WIDTH+FLAGS_WIDTH) register array plus count register. The array is not reset. Entry i is valid only for i < count.
- Top = entry[count-1]. out_top_* are combinational from the array and count, and are forced to 0 when count == 0.
- Per-cycle action, evaluated in priority order:
  - in_clear=1: count←0, overflow←0, underflow←0. Push and pop are ignored.
  - push only, not full: entry[count]←{in_pc,in_flags}, count←count+1.
  - push only, full: no write, count unchanged, overflow←1.
  - pop only, not empty: count←count-1. Popped data is the out_top_* value in the cycle the pop is asserted.
  - pop only, empty: count unchanged, underflow←1.
  - push+pop, not empty (including full): entry[count-1]←{in_pc,in_flags}, count unchanged (replace top). No error flag.
  - push+pop, empty: performed as push only (count←1), underflow←1.
  - neither: hold.
- Error flags are sticky: once set they stay set until in_clear or reset. An error never corrupts the stored contents.
- count arithmetic is CW bits wide and never wraps. Saturation is enforced by the full/empty checks above.

## Timing
- Reset (rst_n=0, asynchronous): count=0, overflow=0, underflow=0. Hence out_empty=1, out_full=0, out_top_pc=0, out_top_flags=0. These outputs apply immediately, with no clock required.
- Reset asserted mid-operation discards all entries. After deassertion the stack is empty.
- Push visible at out_top_*/out_count one cycle after the edge that samples it (latency 1).
- Pop: data valid combinationally in the same cycle as in_pop_en. count and top update at the next edge.
- Error flags rise at the edge that samples the illegal request and are visible in the following cycle.
- Back-to-back push or pop every cycle is supported. There is no handshake or stall; the control unit is responsible for legality.
- out_empty and out_full are combinational decodes of count and change only at clock edges.

## Test plan
All scenarios use DEPTH=4, ADDR_WIDTH=9, FLAGS_WIDTH=4.
1. Reset then idle:
   - Stimulus: assert rst_n=0 without a clock edge.
   - Required: out_count=0, out_empty=1, out_top_pc=0, out_top_flags=0, both error flags 0.
2. Fill then drain:
   - Stimulus: push (0x1E1,0x9), (0x0F0,0x1), (0x100,0x5), (0x003,0xF), then pop 4 times.
   - Required: out_full=1 after the 4th push. Pops return 0x003/F, 0x100/5, 0x0F0/1, 0x1E1/9 in that order. Then out_empty=1 and no error flag is set.
3. Overflow:
   - Stimulus: when full, push (0x055,0x2).
   - Required: out_overflow=1, out_count=4, top still 0x003/F. A subsequent 4 pops return the original data.
4. Underflow and push+pop on empty:
   - Stimulus A: when empty, pop.
   - Required A: out_underflow=1, out_count=0.
   - Stimulus B: in_clear, then push+pop with (0x0AA,0x3).
   - Required B: out_count=1, top 0x0AA/3, out_underflow=1.
5. Replace top:
   - Stimulus: with 2 entries (0x010/1, 0x020/2), assert push+pop with (0x030,0x4).
   - Required: out_count=2, top 0x030/4. A pop then exposes 0x010/1.
6. Clear priority and async reset mid-fill:
   - Stimulus A: with overflow set, assert clear+push together.
   - Required A: count=0 and both flags 0.
   - Stimulus B: after 3 pushes, pulse rst_n low between clock edges.
   - Required B: count=0 immediately, out_top_pc=0.
